ff_sqr_seq: RTL and testbench

- Iterative repeated-squaring sequencer for GF(2^163), reduction polynomial x^163+x^7+x^6+x^3+1. Computes c = a^(2^k) by repeatedly applying the combinational ff_squarer to a state register.
- Sits between the inversion/exponentiation controller (Itoh-Tsujii chain) and the squarer datapath. Owns the operand register, iteration counter and start/done handshake.
- Chains SQR_PER_CYC squarer instances per clock to trade area for latency.

---
 rtl/ff_sqr_seq.sv | 142 ++++++++++++++
 tb/tb_ff_sqr_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_sqr_seq.sv
// rtl/ff_sqr_seq.sv - iterative repeated-squaring sequencer for GF(2^163)
//
// ff_squarer : combinational y = a^2 mod (x^163 + x^7 + x^6 + x^3 + 1)
//   a [162:0] in  : field element
//   y [162:0] out : a squared
//
// ff_sqr_seq : c = a^(2^k), SQR_PER_CYC squarings per RUN cycle
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   start, abort  : request (taken only when ready) / cancel of current run
//   k [KW-1:0]    : number of squarings, sampled with accepted start
//   a [162:0]     : operand, sampled with accepted start
//   ready         : IDLE, start may be taken this cycle
//   busy          : RUN or DONE
//   done          : one-cycle pulse, c valid
//   c [162:0]     : result register, held until the next completed run

module ff_squarer (
  input  logic [162:0] a,
  output logic [162:0] y
);

  logic [324:0] t;

  always_comb begin
    t = '0;
    // Squaring in characteristic 2 just interleaves zeros between the bits.
    for (int i = 0; i < 163; i++) begin
      t[2*i] = a[i];
    end
    // Fold from the top down so bits produced by a fold (at most i-156)
    // are themselves folded on a later iteration when still >= 163.
    for (int i = 324; i >= 163; i--) begin
      if (t[i]) begin
        t[i-163] = t[i-163] ^ 1'b1;
        t[i-160] = t[i-160] ^ 1'b1;
        t[i-157] = t[i-157] ^ 1'b1;
        t[i-156] = t[i-156] ^ 1'b1;
        t[i]     = 1'b0;
      end
    end
    y = t[162:0];
  end

endmodule

module ff_sqr_seq #(
  parameter int SQR_PER_CYC = 1,
  parameter int KW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [KW-1:0] k,
  input  logic [162:0]  a,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [162:0]  c
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q;
  logic [162:0]  op_q;
  logic [KW-1:0] cnt_q;
  logic [162:0]  c_q;

  // tap[j] = op_q squared j times
  logic [162:0]  tap [SQR_PER_CYC+1];
  logic [2:0]    m;
  logic [162:0]  op_step;

  assign tap[0] = op_q;

  for (genvar g = 0; g < SQR_PER_CYC; g++) begin : g_sqr
    ff_squarer u_sqr (
      .a (tap[g]),
      .y (tap[g+1])
    );
  end

  // On the last step fewer than SQR_PER_CYC squarings may remain, so pick
  // the matching intermediate tap instead of the end of the chain.
  always_comb begin
    if (cnt_q >= KW'(SQR_PER_CYC)) begin
      m = 3'(SQR_PER_CYC);
    end else begin
      m = cnt_q[2:0];
    end
    op_step = op_q;
    for (int j = 1; j <= SQR_PER_CYC; j++) begin
      if (m == 3'(j)) begin
        op_step = tap[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            op_q    <= a;
            cnt_q   <= k;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            c_q     <= op_q;
            state_q <= DONE;
          end else begin
            op_q  <= op_step;
            cnt_q <= cnt_q - KW'(m);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN) || (state_q == DONE);
  assign done  = (state_q == DONE);
  assign c     = c_q;

endmodule

// File: tb/tb_ff_sqr_seq.sv
// tb/tb_ff_sqr_seq.sv - scoreboard bench for ff_sqr_seq at S=1, S=4 and S=3

module tb_ff_sqr_seq;

  typedef struct {
    logic [162:0] c;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [7:0]   k;
  logic [162:0] a;
  logic [2:0]   ready_w;
  logic [2:0]   busy_w;
  logic [2:0]   done_w;
  logic [162:0] c_w [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t sbq [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ff_sqr_seq #(
      .SQR_PER_CYC ((g == 0) ? 1 : ((g == 1) ? 4 : 3)),
      .KW          (8)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .k     (k),
      .a     (a),
      .ready (ready_w[g]),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .c     (c_w[g])
    );
  end

  function automatic int s_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 3);
  endfunction

  function automatic logic [162:0] rnd163();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[162:0];
  endfunction

  function automatic logic [162:0] bits(input int b0, input int b1, input int b2,
                                        input int b3, input int b4);
    logic [162:0] v;
    v = '0;
    if (b0 >= 0) v[b0] = 1'b1;
    if (b1 >= 0) v[b1] = 1'b1;
    if (b2 >= 0) v[b2] = 1'b1;
    if (b3 >= 0) v[b3] = 1'b1;
    if (b4 >= 0) v[b4] = 1'b1;
    return v;
  endfunction

  task automatic chk1(input string name, input int i, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %b want %b", name, i, got, want);
    end
  endtask

  task automatic chkc(input string name, input int i, input logic [162:0] got,
                      input logic [162:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %h want %h", name, i, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation for that DUT.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_w[i] === 1'b1) begin
        checks++;
        if (sbq[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_done dut%0d at cycle %0d c %h", i, cyc, c_w[i]);
        end else begin
          e = sbq[i].pop_front();
          if (c_w[i] !== e.c) begin
            errors++;
            $display("FAIL result dut%0d got %h want %h", i, c_w[i], e.c);
          end
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL latency dut%0d got cycle %0d want cycle %0d", i, cyc, e.cyc);
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (ready_w !== 3'b111 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got ready %b want 111", ready_w);
    end
  endtask

  // Returns #1 after the accepting edge E0.
  task automatic issue(input logic [162:0] av, input logic [7:0] kv,
                       input logic [162:0] cexp, input bit push);
    exp_t e;
    wait_idle();
    a     = av;
    k     = kv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      for (int i = 0; i < 3; i++) begin
        e.c   = cexp;
        e.cyc = cyc + (int'(kv) + s_of(i) - 1) / s_of(i) + 1;
        sbq[i].push_back(e);
      end
    end
  endtask

  logic [162:0] ra, rb, x128, x256, x324;

  initial begin
    exp_t e;
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b0;
    k     = 8'd0;
    ra    = rnd163();
    a     = ra;
    x128  = bits(128, -1, -1, -1, -1);
    x256  = bits(100, 99, 96, 93, -1);
    x324  = bits(161, 12, 10, 5, 1);

    // Reset held with start high: nothing may be taken.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk1("rst_ready", i, ready_w[i], 1'b1);
      chk1("rst_busy", i, busy_w[i], 1'b0);
      chk1("rst_done", i, done_w[i], 1'b0);
      chkc("rst_c", i, c_w[i], '0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk1("rel_busy", i, busy_w[i], 1'b0);
    // First edge with rst_n high takes the held start with k=0.
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e.c   = ra;
      e.cyc = cyc + 1;
      sbq[i].push_back(e);
    end

    issue(bits(0, -1, -1, -1, -1), 8'd5, bits(0, -1, -1, -1, -1), 1'b1);
    issue(bits(1, -1, -1, -1, -1), 8'd1, bits(2, -1, -1, -1, -1), 1'b1);
    issue(bits(1, -1, -1, -1, -1), 8'd7, x128, 1'b1);
    issue(bits(1, -1, -1, -1, -1), 8'd8, x256, 1'b1);
    issue(bits(162, -1, -1, -1, -1), 8'd1, x324, 1'b1);
    issue(bits(1, -1, -1, -1, -1), 8'd4, bits(16, -1, -1, -1, -1), 1'b1);
    ra = rnd163();
    issue(ra, 8'd163, ra, 1'b1);
    rb = rnd163();
    issue(rb, 8'd0, rb, 1'b1);

    // Starts while every DUT is busy must be dropped.
    issue(bits(1, -1, -1, -1, -1), 8'd7, x128, 1'b1);
    start = 1'b1;
    a     = rnd163();
    k     = 8'd3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    start = 1'b0;

    // c must hold while inputs wander.
    wait_idle();
    for (int n = 0; n < 10; n++) begin
      for (int i = 0; i < 3; i++) chkc("hold_c", i, c_w[i], x128);
      a = rnd163();
      k = 8'($urandom);
      @(negedge clk);
    end

    // abort beats start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk1("abort_idle_busy", i, busy_w[i], 1'b0);

    // abort in the third RUN cycle of k=20.
    issue(bits(1, -1, -1, -1, -1), 8'd20, '0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk1("abort_ready", i, ready_w[i], 1'b1);
      chkc("abort_c", i, c_w[i], x128);
    end
    repeat (30) @(negedge clk);

    // Reset in the middle of a run.
    issue(bits(1, -1, -1, -1, -1), 8'd20, '0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chkc("midrst_c", i, c_w[i], '0);
      chk1("midrst_busy", i, busy_w[i], 1'b0);
      chk1("midrst_done", i, done_w[i], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    issue(bits(1, -1, -1, -1, -1), 8'd2, bits(4, -1, -1, -1, -1), 1'b1);

    wait_idle();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (sbq[i].size() != 0) begin
        errors++;
        $display("FAIL missing_done dut%0d got %0d pending want 0", i, sbq[i].size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
